// File: rtl/param_updown_counter_pkg.sv
// Shared constants and config helpers for the up/down counter.
// Direction/mode encodings plus a parameter sanity function.
package param_updown_counter_pkg;

  localparam logic CNT_UP = 1'b1;
  localparam logic CNT_DN = 1'b0;

  localparam int CNT_WRAP = 0;
  localparam int CNT_SAT  = 1;

  // Legal when 2 <= m <= 2**w and 0 <= rv < m.
  function automatic bit cfg_ok(
    input int w,
    input int m,
    input int rv
  );
    longint lim;
    lim = longint'(1) << w;
    return (w >= 1) && (m >= 2) &&
           (longint'(m) <= lim) &&
           (rv >= 0) && (rv < m);
  endfunction

endpackage

// File: rtl/counter_next_logic.sv
// Combinational next-count and boundary detection for the counter.
// Ports: count/up_dn/en/load/load_val in; next_count/boundary out.
module counter_next_logic
  import param_updown_counter_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int MODULUS  = 2 ** WIDTH,
  parameter int SATURATE = CNT_WRAP
) (
  input  logic [WIDTH-1:0] count,
  input  logic             up_dn,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] next_count,
  output logic             boundary
);

  // One extra bit so MODULUS == 2**WIDTH is representable.
  localparam logic [WIDTH:0] MOD_X =
    (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH-1:0] MAX =
    WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] ONE =
    WIDTH'(1);

  logic is_up;
  logic at_top;
  logic at_bot;
  logic ld_big;
  logic step_up;
  logic step_dn;

  assign is_up   = (up_dn == CNT_UP);
  assign at_top  = (count == MAX);
  assign at_bot  = (count == '0);
  assign ld_big  = ({1'b0, load_val} >= MOD_X);
  assign step_up = !load && en && is_up;
  assign step_dn = !load && en && !is_up;

  always_comb begin
    next_count = count;
    boundary   = 1'b0;
    unique case (1'b1)
      load: begin
        next_count = ld_big ? MAX : load_val;
      end
      step_up: begin
        if (at_top) begin
          boundary = 1'b1;
          if (SATURATE == CNT_WRAP)
            next_count = '0;
        end else begin
          next_count = count + ONE;
        end
      end
      step_dn: begin
        if (at_bot) begin
          boundary = 1'b1;
          if (SATURATE == CNT_WRAP)
            next_count = MAX;
        end else begin
          next_count = count - ONE;
        end
      end
      default: begin
        next_count = count;
      end
    endcase
  end

endmodule

// File: rtl/param_updown_counter.sv
// Parametrised up/down counter with wrap/saturate, tc pulse, sticky ovf.
// Ports: clk, rst(n), en, up_dn, clr, load, load_val in; count, tc, ovf out.
module param_updown_counter
  import param_updown_counter_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int MODULUS   = 2 ** WIDTH,
  parameter int SATURATE  = CNT_WRAP,
  parameter int RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf
);

  if (!cfg_ok(WIDTH, MODULUS, RESET_VAL))
  begin : g_cfg_err
    $error("param_updown_counter: bad MODULUS/RESET_VAL");
  end

  localparam logic [WIDTH-1:0] RST_CNT =
    WIDTH'(RESET_VAL);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic             tc_q;
  logic             tc_d;
  logic             ovf_q;
  logic             ovf_d;

  logic [WIDTH-1:0] nxt;
  logic             bnd;

  counter_next_logic #(
    .WIDTH    (WIDTH),
    .MODULUS  (MODULUS),
    .SATURATE (SATURATE)
  ) u_next (
    .count      (count_q),
    .up_dn      (up_dn),
    .en         (en),
    .load       (load),
    .load_val   (load_val),
    .next_count (nxt),
    .boundary   (bnd)
  );

  // clr outranks load/en; reset is applied in the register.
  always_comb begin
    count_d = nxt;
    tc_d    = bnd;
    ovf_d   = ovf_q | bnd;
    if (clr) begin
      count_d = RST_CNT;
      tc_d    = 1'b0;
      ovf_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= RST_CNT;
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count = count_q;
  assign tc    = tc_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_param_updown_counter.sv
// Scoreboard bench: wrap (MOD 10) and saturate (MOD 10) instances.
// Stimulus pushes expectations; a negedge monitor pops and compares.
module tb_param_updown_counter;

  localparam int M = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       up_dn = 1'b0;
  logic       clr = 1'b0;
  logic       load = 1'b0;
  logic [3:0] load_val = '0;

  logic [3:0] cnt_w;
  logic       tc_w;
  logic       ov_w;
  logic [3:0] cnt_s;
  logic       tc_s;
  logic       ov_s;

  always #5 clk = ~clk;

  param_updown_counter #(
    .WIDTH(4), .MODULUS(M),
    .SATURATE(0), .RESET_VAL(0)
  ) dut_w (
    .clk(clk), .rst(rst), .en(en),
    .up_dn(up_dn), .clr(clr), .load(load),
    .load_val(load_val), .count(cnt_w),
    .tc(tc_w), .ovf(ov_w)
  );

  param_updown_counter #(
    .WIDTH(4), .MODULUS(M),
    .SATURATE(1), .RESET_VAL(0)
  ) dut_s (
    .clk(clk), .rst(rst), .en(en),
    .up_dn(up_dn), .clr(clr), .load(load),
    .load_val(load_val), .count(cnt_s),
    .tc(tc_s), .ovf(ov_s)
  );

  typedef struct {
    int c;
    bit t;
    bit o;
  } exp_t;

  exp_t qw[$];
  exp_t qs[$];

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm,
                     input int act,
                     input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else
      $display("FAIL %s: got %0d want %0d @%0t",
               nm, act, exp, $time);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (qw.size() > 0) begin
      e = qw.pop_front();
      chk("w_count", int'(cnt_w), e.c);
      chk("w_tc", int'(tc_w), int'(e.t));
      chk("w_ovf", int'(ov_w), int'(e.o));
    end
    if (qs.size() > 0) begin
      e = qs.pop_front();
      chk("s_count", int'(cnt_s), e.c);
      chk("s_tc", int'(tc_s), int'(e.t));
      chk("s_ovf", int'(ov_s), int'(e.o));
    end
  end

  task automatic cyc(input bit r, input bit cl,
                     input bit ld, input bit e,
                     input bit u, input int lv);
    @(negedge clk);
    rst = r;
    clr = cl;
    load = ld;
    en = e;
    up_dn = u;
    load_val = 4'(lv);
    @(posedge clk);
  endtask

  task automatic ew(input int c, input bit t,
                    input bit o);
    exp_t e;
    e.c = c; e.t = t; e.o = o;
    qw.push_back(e);
  endtask

  task automatic es(input int c, input bit t,
                    input bit o);
    exp_t e;
    e.c = c; e.t = t; e.o = o;
    qs.push_back(e);
  endtask

  // Reference behaviour written from the functional description.
  task automatic mstep(input bit sat,
                       inout int c, inout bit t,
                       inout bit o, input bit r,
                       input bit cl, input bit ld,
                       input bit e, input bit u,
                       input int lv);
    if (!r || cl) begin
      c = 0; t = 0; o = 0;
    end else if (ld) begin
      c = (lv >= M) ? M - 1 : lv;
      t = 0;
    end else if (e) begin
      if ((u && c == M - 1) || (!u && c == 0)) begin
        t = 1; o = 1;
        if (!sat) c = u ? 0 : M - 1;
      end else begin
        t = 0;
        c = u ? c + 1 : c - 1;
      end
    end else begin
      t = 0;
    end
  endtask

  initial begin
    int dn[5];
    int uw[4];
    int cw, cs;
    bit tw, ts, ow, os;
    bit r, cl, ld, e, u;
    int lv;

    dn = '{2, 1, 0, 9, 8};
    uw = '{5, 4, 5, 4};

    // Reset held two cycles.
    repeat (2) begin
      cyc(0, 0, 0, 0, 0, 0);
      ew(0, 0, 0); es(0, 0, 0);
    end

    // Count up through the wrap.
    for (int i = 1; i <= 10; i++) begin
      cyc(1, 0, 0, 1, 1, 0);
      ew(i % 10, i == 10, i == 10);
    end
    cyc(1, 0, 0, 0, 1, 0);
    ew(0, 0, 1);

    // Load 3 then count down across zero.
    cyc(1, 0, 1, 0, 0, 3);
    ew(3, 0, 1);
    for (int i = 0; i < 5; i++) begin
      cyc(1, 0, 0, 1, 0, 0);
      ew(dn[i], i == 3, 1);
    end

    // Clamp on oversized load; clr beats load.
    cyc(1, 0, 1, 1, 1, 14);
    ew(9, 0, 1);
    cyc(1, 1, 1, 1, 1, 5);
    ew(0, 0, 0); es(0, 0, 0);

    // Saturating instance: hold at top.
    cyc(1, 0, 1, 0, 1, 8);
    es(8, 0, 0);
    cyc(1, 0, 0, 1, 1, 0);
    es(9, 0, 0);
    cyc(1, 0, 0, 1, 1, 0);
    es(9, 1, 1);
    cyc(1, 0, 0, 1, 1, 0);
    es(9, 1, 1);
    cyc(1, 0, 0, 1, 0, 0);
    es(8, 0, 1);
    cyc(1, 1, 0, 0, 0, 0);
    ew(0, 0, 0); es(0, 0, 0);

    // Saturating instance: hold at bottom.
    cyc(1, 0, 0, 1, 0, 0);
    es(0, 1, 1);

    // Reset mid-count, then resume; en=0 holds.
    cyc(1, 1, 0, 0, 0, 0);
    ew(0, 0, 0); es(0, 0, 0);
    cyc(1, 0, 1, 0, 1, 5);
    ew(5, 0, 0);
    cyc(1, 0, 0, 1, 1, 0);
    ew(6, 0, 0);
    cyc(0, 0, 0, 1, 1, 0);
    ew(0, 0, 0); es(0, 0, 0);
    cyc(1, 0, 0, 1, 1, 0);
    ew(1, 0, 0);
    repeat (2) begin
      cyc(1, 0, 0, 0, 1, 0);
      ew(1, 0, 0);
    end

    // Direction flips every cycle.
    cyc(1, 0, 1, 0, 0, 4);
    ew(4, 0, 0);
    for (int i = 0; i < 4; i++) begin
      cyc(1, 0, 0, 1, (i % 2) == 0, 0);
      ew(uw[i], 0, 0);
    end

    // Random phase against the reference model.
    cyc(1, 1, 0, 0, 0, 0);
    ew(0, 0, 0); es(0, 0, 0);
    cw = 0; cs = 0;
    tw = 0; ts = 0; ow = 0; os = 0;
    for (int i = 0; i < 300; i++) begin
      r  = ($urandom_range(0, 29) != 0);
      cl = ($urandom_range(0, 24) == 0);
      ld = ($urandom_range(0, 7) == 0);
      e  = ($urandom_range(0, 3) != 0);
      u  = $urandom_range(0, 1) == 1;
      lv = int'($urandom_range(0, 15));
      cyc(r, cl, ld, e, u, lv);
      mstep(0, cw, tw, ow, r, cl, ld, e, u, lv);
      mstep(1, cs, ts, os, r, cl, ld, e, u, lv);
      ew(cw, tw, ow);
      es(cs, ts, os);
    end

    repeat (3) @(negedge clk);
    chk("drain_w", qw.size(), 0);
    chk("drain_s", qs.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
